// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per execution unit, a round-robin
// pick among the held results, and a registered single-cycle broadcast of the winner.
module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int TAG_W   = 4,
  parameter int ID_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC*TAG_W-1:0] src_tag,
  input  logic [NUM_SRC*ID_W-1:0]  src_inst_id,
  input  logic [NUM_SRC*32-1:0]    src_wdata,
  output logic                     cdb_wr,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [ID_W-1:0]          cdb_inst_id,
  output logic [31:0]              cdb_wdata
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [NUM_SRC-1:0]             hold_valid;
  logic [NUM_SRC-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_SRC-1:0][ID_W-1:0]   hold_id;
  logic [NUM_SRC-1:0][31:0]       hold_data;

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic [SUM_W-1:0]   cand;

  logic             cdb_wr_reg;
  logic [TAG_W-1:0] cdb_tag_reg;
  logic [ID_W-1:0]  cdb_id_reg;
  logic [31:0]      cdb_data_reg;

  // Grant looks only at the holding registers, so src_ready never depends on src_valid.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = {1'b0, rr_ptr_reg} + SUM_W'(off);
      if (cand >= SUM_W'(NUM_SRC)) begin
        cand = cand - SUM_W'(NUM_SRC);
      end
      if (!any_grant && hold_valid[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  assign src_ready   = ~hold_valid | grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_hold
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [ID_W-1:0]  id_reg;
      logic [31:0]      data_reg;
      logic             load;

      assign load = src_valid[gi] & src_ready[gi];

      // A reload in the same cycle as a grant keeps the entry valid for streaming.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          id_reg    <= '0;
          data_reg  <= '0;
        end else if (load) begin
          valid_reg <= 1'b1;
          tag_reg   <= src_tag[gi*TAG_W +: TAG_W];
          id_reg    <= src_inst_id[gi*ID_W +: ID_W];
          data_reg  <= src_wdata[gi*32 +: 32];
        end else if (grant[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign hold_valid[gi] = valid_reg;
      assign hold_tag[gi]   = tag_reg;
      assign hold_id[gi]    = id_reg;
      assign hold_data[gi]  = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      cdb_wr_reg   <= 1'b0;
      cdb_tag_reg  <= '0;
      cdb_id_reg   <= '0;
      cdb_data_reg <= '0;
    end else begin
      cdb_wr_reg <= any_grant;
      if (any_grant) begin
        rr_ptr_reg   <= rr_ptr_next;
        cdb_tag_reg  <= hold_tag[grant_idx];
        cdb_id_reg   <= hold_id[grant_idx];
        cdb_data_reg <= hold_data[grant_idx];
      end
    end
  end

  assign cdb_wr      = cdb_wr_reg;
  assign cdb_tag     = cdb_tag_reg;
  assign cdb_inst_id = cdb_id_reg;
  assign cdb_wdata   = cdb_data_reg;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects completed results from the execution units (ALU, MDU, LSU) and drives the common data bus (CDB) that the reorder buffer and reservation stations snoop.
- Each source has a one-entry holding register. A round-robin arbiter picks one held result per cycle.
- The winning result is registered onto the CDB as a single-cycle write pulse carrying tag, inst_id and wdata.

Parameters:
- NUM_SRC, 3, number of execution-unit sources (index 0=ALU, 1=MDU, 2=LSU).
- TAG_W, 4, width of the functional-unit/rename tag; tag value 0 is reserved for "no tag".
- ID_W, 4, width of the ROB inst_id (log2 of ROB depth).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- src_valid, input, NUM_SRC, per-source result valid.
- src_ready, output, NUM_SRC, per-source result accepted this cycle.
- src_tag, input, NUM_SRC*TAG_W, per-source tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_inst_id, input, NUM_SRC*ID_W, per-source ROB inst_id, packed the same way.
- src_wdata, input, NUM_SRC*32, per-source result data, packed the same way.
- cdb_wr, output, 1, CDB broadcast valid (one-cycle pulse per result).
- cdb_tag, output, TAG_W, broadcast tag.
- cdb_inst_id, output, ID_W, broadcast ROB index.
- cdb_wdata, output, 32, broadcast result.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All hold_valid = 0; rr_ptr = 0.
  - cdb_wr = 0; cdb_tag, cdb_inst_id and cdb_wdata = 0.
  - src_ready evaluates to all-ones in the following cycle.
  - Reset mid-operation discards all held results; nothing is broadcast.
- Holding register per source i: hold_valid, hold_tag, hold_id, hold_data.
- Source handshake:
  - src_ready[i] = ~hold_valid[i] | grant[i] (combinational).
  - grant depends only on hold_valid and rr_ptr, never on src_valid, so there is no combinational loop.
  - Transfer occurs when src_valid[i] & src_ready[i] at a clk edge: the hold register loads and hold_valid[i] = 1.
  - If grant[i] and there is no new transfer, hold_valid[i] clears.
  - If grant[i] and a new transfer happen in the same cycle, the hold register reloads and hold_valid stays 1, giving back-to-back throughput of 1 result/cycle per source.
  - Source contract: it must hold src_* stable while src_valid & ~src_ready.
- Arbitration (combinational):
  - Scan hold_valid starting at index rr_ptr, ascending and wrapping modulo NUM_SRC.
  - The first set entry wins; grant is one-hot or zero.
- Pointer update:
  - On a grant to k, rr_ptr <= (k+1) mod NUM_SRC. Wrap from NUM_SRC-1 goes to 0.
  - With no grant, rr_ptr is unchanged.
- CDB output (registered):
  - If any grant: cdb_wr <= 1 and cdb_tag/inst_id/wdata <= the winner's hold fields.
  - Otherwise cdb_wr <= 0 and the data fields hold their previous value. Consumers must ignore them when cdb_wr=0.
- Latency: a result accepted at edge E0 is held during cycle E0→E1. If granted, cdb_wr=1 from E1 to E2. Minimum input-to-broadcast latency is 2 edges.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,0,... Any held result is broadcast within NUM_SRC cycles.
- Capacity: at most NUM_SRC results are buffered. Per-source backpressure occurs only when that source's hold is full and it is not granted.
- Tag 0: a held entry with tag 0 is illegal. The bench asserts the tag is never 0 on transfer; the RTL does not filter it.
- No flush input; speculative squash is out of scope for this block.

Test Plan:
- Reset then idle: rst 1 for 2 cycles → cdb_wr=0, cdb_tag=0, src_ready=3'b111, and these stay the same for 10 idle cycles.
- Single result: ALU presents tag=4'h3, id=4'h5, wdata=32'hDEADBEEF for one cycle → next cycle src_ready[0]=1; two edges later cdb_wr=1 for exactly one cycle with tag=3, id=5, wdata=DEADBEEF.
- Three-way contention: all three sources load in the same cycle (tags 1,2,3) with rr_ptr=0 → broadcasts in consecutive cycles in order tag 1,2,3; afterwards rr_ptr=0 (wrap).
- Backpressure: MDU holds tag=2 while ALU streams tags 1,1,1... continuously from rr_ptr=1 → MDU broadcast first; ALU then alternates with MDU refills. src_ready[1]=0 only on cycles when the MDU hold is full and not granted. No result is lost or duplicated (scoreboard check).
- Back-to-back single source: LSU presents 8 results on consecutive cycles (ids 0..7, wdata=id*32'h11), no other sources → src_ready[2] stays 1 and 8 consecutive cdb_wr pulses arrive in id order.
- Reset mid-operation: all three holds full, assert rst for 1 cycle → no cdb_wr during or after the reset cycle, rr_ptr=0, and a new ALU result tag=7 broadcasts normally.
